// File: rtl/dict_finder_pkg.sv
// Shared definitions for the dictionary finder: FSM states, entry layout
// offsets, the chain terminator and the case-folding helper.
package dict_finder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN,
        ST_LENC,
        ST_TCH,
        ST_DCH,
        ST_CMP,
        ST_OPR,
        ST_OPV,
        ST_LNKL,
        ST_LNKH,
        ST_LNKV,
        ST_DONE
    } finder_st_e;

    // A link of all ones marks the end of the dictionary chain.
    localparam logic [15:0] LFA_NULL = 16'hFFFF;

    // Byte offsets of the fields inside one dictionary entry.
    localparam int LFA_OFF  = 0;
    localparam int LEN_OFF  = 2;
    localparam int NAME_OFF = 3;

    // Map ASCII 'A'..'Z' onto 'a'..'z'; every other byte passes through.
    function automatic logic [7:0] fold_lc(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A)
            return c + 8'h20;
        return c;
    endfunction

endpackage

// File: rtl/mb8_io.sv
// Shared 8-bit byte-memory bus: registered address out, read data back
// one state later.
interface mb8_io #(
    parameter int ASZ = 17
);
    logic [ASZ-1:0] ai;
    logic           we;
    logic [7:0]     vi;
    logic [7:0]     vo;

    modport master (output ai, output we, output vi, input vo);
    modport slave  (input ai, input we, input vi, output vo);
endinterface

// File: rtl/dict_finder.sv
// Dictionary search engine: walks the link chain from ctx, compares the
// token in TIB against each entry name (case-insensitive) and returns the
// opcode and its address for the first match. Read-only bus master.
module dict_finder
    import dict_finder_pkg::*;
#(
    parameter int ASZ = 17
) (
    input  logic           clk,
    input  logic           rst,
    mb8_io.master          b8_if,
    input  logic           start,
    input  logic [ASZ-1:0] ctx,
    input  logic [ASZ-1:0] tok_ai,
    input  logic [7:0]     tok_len,
    output logic           busy,
    output logic           done,
    output logic           found,
    output logic [7:0]     op,
    output logic [ASZ-1:0] pfa
);

    finder_st_e     state, state_nx;

    logic [ASZ-1:0] cur;        // entry being examined
    logic [7:0]     idx;        // name character index
    logic [7:0]     tch;        // TIB character held for the compare
    logic [7:0]     lo;         // link low byte held while reading the high byte
    logic [ASZ-1:0] tok_ai_r;
    logic [7:0]     tok_len_r;

    logic [ASZ-1:0] idx_ext;
    logic [ASZ-1:0] op_addr;
    logic [15:0]    link;

    assign idx_ext = ASZ'(idx);
    assign op_addr = cur + ASZ'(NAME_OFF) + ASZ'(tok_len_r);
    assign link    = {b8_if.vo, lo};

    // The finder never writes memory.
    assign b8_if.we = 1'b0;
    assign b8_if.vi = 8'h00;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Next-state decode and status outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nx = state;
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (tok_len == 8'd0 || ctx[15:0] == LFA_NULL)
                        state_nx = ST_DONE;
                    else
                        state_nx = ST_LEN;
                end
            end
            ST_LEN:  state_nx = ST_LENC;
            ST_LENC: state_nx = (b8_if.vo != tok_len_r) ? ST_LNKL : ST_TCH;
            ST_TCH:  state_nx = ST_DCH;
            ST_DCH:  state_nx = ST_CMP;
            ST_CMP: begin
                if (fold_lc(b8_if.vo) != fold_lc(tch))
                    state_nx = ST_LNKL;
                else if (idx == tok_len_r - 8'd1)
                    state_nx = ST_OPR;
                else
                    state_nx = ST_TCH;
            end
            ST_OPR:  state_nx = ST_OPV;
            ST_OPV:  state_nx = ST_DONE;
            ST_LNKL: state_nx = ST_LNKH;
            ST_LNKH: state_nx = ST_LNKV;
            ST_LNKV: state_nx = (link == LFA_NULL) ? ST_DONE : ST_LEN;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath: bus address, latched request, walk pointers and results.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= '0;
            idx       <= '0;
            tch       <= '0;
            lo        <= '0;
            tok_ai_r  <= '0;
            tok_len_r <= '0;
            found     <= 1'b0;
            op        <= '0;
            pfa       <= '0;
            b8_if.ai  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        tok_ai_r  <= tok_ai;
                        tok_len_r <= tok_len;
                        cur       <= ctx;
                        found     <= 1'b0;
                    end
                end
                ST_LEN:  b8_if.ai <= cur + ASZ'(LEN_OFF);
                ST_LENC: idx <= 8'd0;
                ST_TCH:  b8_if.ai <= tok_ai_r + idx_ext;
                ST_DCH: begin
                    tch      <= b8_if.vo;
                    b8_if.ai <= cur + ASZ'(NAME_OFF) + idx_ext;
                end
                // Advancing on a mismatch is harmless: LENC reloads idx.
                ST_CMP:  idx <= idx + 8'd1;
                ST_OPR:  b8_if.ai <= op_addr;
                ST_OPV: begin
                    op    <= b8_if.vo;
                    pfa   <= op_addr;
                    found <= 1'b1;
                end
                ST_LNKL: b8_if.ai <= cur + ASZ'(LFA_OFF);
                ST_LNKH: begin
                    lo       <= b8_if.vo;
                    b8_if.ai <= cur + ASZ'(LFA_OFF + 1);
                end
                ST_LNKV: begin
                    if (link != LFA_NULL)
                        cur <= ASZ'(link);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dict_finder.sv
// Bench for dict_finder: loads the standard dictionary and TIB into a byte
// memory clocked on the falling edge, issues directed searches and checks
// results and latency through a scoreboard popped on every done pulse.
module tb_dict_finder;

    localparam int ASZ = 17;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [ASZ-1:0] ctx = '0;
    logic [ASZ-1:0] tok_ai = '0;
    logic [7:0]     tok_len = '0;
    logic           busy, done, found;
    logic [7:0]     op;
    logic [ASZ-1:0] pfa;

    mb8_io #(.ASZ(ASZ)) b8 ();

    dict_finder #(.ASZ(ASZ)) dut (
        .clk     (clk),
        .rst     (rst),
        .b8_if   (b8),
        .start   (start),
        .ctx     (ctx),
        .tok_ai  (tok_ai),
        .tok_len (tok_len),
        .busy    (busy),
        .done    (done),
        .found   (found),
        .op      (op),
        .pfa     (pfa)
    );

    always #5 clk = ~clk;

    // Byte memory read on the falling edge.
    logic [7:0] mem [0:(1<<ASZ)-1];
    always @(negedge clk) b8.vo <= mem[b8.ai];

    localparam logic [7:0] OP_NOP = 8'h01, OP_DUP = 8'h02, OP_DROP = 8'h03,
                           OP_SWAP = 8'h04, OP_ADD = 8'h05, OP_SUB = 8'h06;

    typedef struct {
        logic           fnd;
        logic [7:0]     opc;
        logic [ASZ-1:0] pf;
        int             lat;
        int             s;
        logic           chk_ai;
        logic [ASZ-1:0] ai;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ncnt = 0;
    int   done_cnt = 0;
    int   we_errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts falling edges and checks each done against the queue.
    always @(negedge clk) begin
        exp_t e;
        ncnt++;
        if (b8.we !== 1'b0) we_errs++;
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("found", {31'd0, found}, {31'd0, e.fnd});
                check("op", {24'd0, op}, {24'd0, e.opc});
                check("pfa", 32'(pfa), 32'(e.pf));
                check("latency", 32'(ncnt - e.s), 32'(e.lat));
                check("busy_at_done", {31'd0, busy}, 32'd1);
                if (e.chk_ai) check("no_bus_read", 32'(b8.ai), 32'(e.ai));
            end
        end
    end

    task automatic put_word(input int a, input logic [15:0] link, input string nm,
                            input logic [7:0] opc);
        mem[ASZ'(a)]     = link[7:0];
        mem[ASZ'(a + 1)] = link[15:8];
        mem[ASZ'(a + 2)] = 8'(nm.len());
        for (int i = 0; i < nm.len(); i++) mem[ASZ'(a + 3 + i)] = nm[i];
        mem[ASZ'(a + 3 + nm.len())] = opc;
    endtask

    task automatic dict_setup();
        string tib;
        for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'h00;
        tib = "123 DUP + 456 -";
        for (int i = 0; i < tib.len(); i++) mem[ASZ'(i)] = tib[i];
        put_word(32'h100, 16'hFFFF, "nop",  OP_NOP);
        put_word(32'h107, 16'h0100, "dup",  OP_DUP);
        put_word(32'h10E, 16'h0107, "drop", OP_DROP);
        put_word(32'h116, 16'h010E, "swap", OP_SWAP);
        put_word(32'h11E, 16'h0116, "+",    OP_ADD);
        put_word(32'h123, 16'h011E, "-",    OP_SUB);
    endtask

    // Drive a one-cycle start; returns #1 after the falling edge of cycle 1.
    // Inputs are scrambled afterwards to show the request was latched.
    task automatic issue(input logic [ASZ-1:0] c, input logic [ASZ-1:0] ta,
                         input logic [7:0] tl, output int s);
        @(negedge clk); #1;
        ctx = c; tok_ai = ta; tok_len = tl; start = 1'b1;
        s = ncnt;
    endtask

    task automatic finish_issue();
        @(negedge clk); #1;
        start = 1'b0;
        ctx = 17'h1ABCD; tok_ai = 17'h0F0F0; tok_len = 8'h5A;
        check("busy_c1", {31'd0, busy}, 32'd1);
    endtask

    task automatic search(input logic [ASZ-1:0] c, input logic [ASZ-1:0] ta,
                          input logic [7:0] tl, input logic fnd, input logic [7:0] opc,
                          input logic [ASZ-1:0] pf, input int lat,
                          input logic chk_ai, input logic [ASZ-1:0] ai);
        int s;
        exp_t e;
        issue(c, ta, tl, s);
        e.fnd = fnd; e.opc = opc; e.pf = pf; e.lat = lat; e.s = s;
        e.chk_ai = chk_ai; e.ai = ai;
        sb.push_back(e);
        finish_issue();
    endtask

    // Bounded wait for the scoreboard to drain, then for busy to drop.
    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            check({name, "_timeout"}, 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int s;
        int d0;
        dict_setup();
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_found", {31'd0, found}, 32'd0);
        check("rst_op",    {24'd0, op},    32'd0);
        check("rst_pfa",   32'(pfa),       32'd0);
        check("rst_ai",    32'(b8.ai),     32'd0);
        rst = 1'b0;

        // "DUP" in upper case matches "dup" after four skipped entries.
        search(17'h123, 17'd4, 8'd3, 1'b1, OP_DUP, 17'h10D, 34, 1'b0, '0);
        wait_idle("dup");
        // "+" skips "-" on a character mismatch.
        search(17'h123, 17'd8, 8'd1, 1'b1, OP_ADD, 17'h122, 16, 1'b0, '0);
        wait_idle("add");
        // "456" walks the whole chain; op/pfa keep the previous result.
        search(17'h123, 17'd10, 8'd3, 1'b0, OP_ADD, 17'h122, 37, 1'b0, '0);
        wait_idle("miss");
        // Early exits: the last address read was the nop link high byte.
        search(17'h123, 17'd4, 8'd0, 1'b0, OP_ADD, 17'h122, 1, 1'b1, 17'h101);
        wait_idle("len0");
        search(17'h0FFFF, 17'd4, 8'd3, 1'b0, OP_ADD, 17'h122, 1, 1'b1, 17'h101);
        wait_idle("ctxnull");

        // Reset in cycle 10 of a DUP search aborts with no done.
        d0 = done_cnt;
        issue(17'h123, 17'd4, 8'd3, s);
        finish_issue();
        while (ncnt < s + 10) @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk); #1;
        check("abort_busy",  {31'd0, busy},  32'd0);
        check("abort_done",  {31'd0, done},  32'd0);
        check("abort_found", {31'd0, found}, 32'd0);
        check("abort_op",    {24'd0, op},    32'd0);
        check("abort_pfa",   32'(pfa),       32'd0);
        check("abort_ai",    32'(b8.ai),     32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        search(17'h123, 17'd4, 8'd3, 1'b1, OP_DUP, 17'h10D, 34, 1'b0, '0);
        wait_idle("after_rst");

        // A second start while busy is ignored.
        d0 = done_cnt;
        search(17'h123, 17'd4, 8'd3, 1'b1, OP_DUP, 17'h10D, 34, 1'b0, '0);
        repeat (3) @(negedge clk);
        #1;
        ctx = 17'h123; tok_ai = 17'd8; tok_len = 8'd0; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_idle("busy_start");
        repeat (10) @(negedge clk);
        #1;
        check("one_done", 32'(done_cnt - d0), 32'd1);

        check("we_never_high", 32'(we_errs), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
